gap_line_array: RTL

Parametrised bank of NUM_LINES horizontal wall lines for the Wild Cube playfield. Each line spans the playfield width with a movable gap whose width is set by switches. Each gap bounces left/right at one step per video frame, with a lane-dependent speed. The block consumes the shared pixel coordinates from the VGA timing counters and produces registered pixel-on flags for the colour mux and for the collision logic.

---
 rtl/wildcube_pkg.sv | 21 ++
 rtl/gap_line_array_lane.sv | 107 ++++++++++
 rtl/gap_line_array.sv | 86 ++++++++
 3 files changed

// File: rtl/wildcube_pkg.sv
// +----------------------------------------------------------------------------+
// | wildcube_pkg: shared types and playfield defaults for the wall-line logic. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package wildcube_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2
  } lane_state_t;

  localparam int CW_DEF    = 10;
  localparam int X_MIN_DEF = 10;
  localparam int X_MAX_DEF = 630;

endpackage

`default_nettype wire

// File: rtl/gap_line_array_lane.sv
// +----------------------------------------------------------------------------+
// | gap_lane: one wall lane - bouncing gap position FSM and wall pixel compare.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gap_lane
  import wildcube_pkg::*;
#(
  parameter int LANE        = 0,
  parameter int CW          = CW_DEF,
  parameter int ROW0        = 90,
  parameter int ROW_PITCH   = 96,
  parameter int THICK       = 9,
  parameter int X_MIN       = X_MIN_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int START_X     = 250,
  parameter int START_PITCH = 64,
  parameter int STEP        = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  logic          i_frame,
  input  logic          i_start,
  input  logic          i_load,
  input  logic          i_run,
  input  logic [2:0]    i_gap_sel,
  output logic          o_wall
);

  localparam logic [CW:0] c_STEP   = (CW+1)'(STEP + LANE);
  localparam logic [CW:0] c_START  = (CW+1)'(START_X + LANE * START_PITCH);
  localparam logic [CW:0] c_ROW_LO = (CW+1)'(ROW0 + LANE * ROW_PITCH);
  localparam logic [CW:0] c_ROW_HI = (CW+1)'(ROW0 + LANE * ROW_PITCH + THICK - 1);
  localparam logic [CW:0] c_X_MIN  = (CW+1)'(X_MIN);
  localparam logic [CW:0] c_X_MAX  = (CW+1)'(X_MAX);

  lane_state_t   r_state;
  lane_state_t   w_state_nxt;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] w_pos_nxt;

  logic [CW:0] w_pos, w_gap, w_x, w_y;
  logic [CW:0] w_fwd, w_back, w_right_clamp;
  logic        w_band, w_in_gap;

  // One extra bit keeps p+s+g from wrapping before the compare.
  assign w_pos         = {1'b0, r_pos};
  assign w_gap         = (CW+1)'({i_gap_sel, 5'b0_0000});
  assign w_x           = {1'b0, i_x};
  assign w_y           = {1'b0, i_y};
  assign w_fwd         = w_pos + c_STEP;
  assign w_back        = w_pos - c_STEP;
  assign w_right_clamp = c_X_MAX - w_gap;

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    if (i_load) begin
      w_state_nxt = IDLE;
      w_pos_nxt   = c_START[CW-1:0];
    end else if (r_state == IDLE) begin
      if (i_start) begin
        w_state_nxt = (LANE % 2 == 1) ? LEFT : RIGHT;
      end
    end else if (i_frame && i_run) begin
      case (r_state)
        RIGHT: begin
          if (w_fwd + w_gap >= c_X_MAX) begin
            w_pos_nxt   = w_right_clamp[CW-1:0];
            w_state_nxt = LEFT;
          end else begin
            w_pos_nxt = w_fwd[CW-1:0];
          end
        end
        LEFT: begin
          if (w_pos <= c_X_MIN + c_STEP) begin
            w_pos_nxt   = c_X_MIN[CW-1:0];
            w_state_nxt = RIGHT;
          end else begin
            w_pos_nxt = w_back[CW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pos   <= c_START[CW-1:0];
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  assign w_band   = (w_y >= c_ROW_LO) && (w_y <= c_ROW_HI);
  assign w_in_gap = (w_x >= w_pos) && (w_x < w_pos + w_gap);
  assign o_wall   = w_band && (w_x >= c_X_MIN) && (w_x < c_X_MAX) && !w_in_gap;

endmodule

`default_nettype wire

// File: rtl/gap_line_array.sv
// +----------------------------------------------------------------------------+
// | gap_line_array: bank of bouncing-gap wall lines with registered pixel flags.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gap_line_array
  import wildcube_pkg::*;
#(
  parameter int NUM_LINES   = 4,
  parameter int CW          = CW_DEF,
  parameter int ROW0        = 90,
  parameter int ROW_PITCH   = 96,
  parameter int THICK       = 9,
  parameter int X_MIN       = X_MIN_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int START_X     = 250,
  parameter int START_PITCH = 64,
  parameter int STEP        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CW-1:0]        x,
  input  logic [CW-1:0]        y,
  input  logic                 frame,
  input  logic                 start,
  input  logic                 load,
  input  logic                 run,
  input  logic                 flash,
  input  logic [2:0]           gap_sel,
  output logic                 line_px,
  output logic                 line_raw,
  output logic [NUM_LINES-1:0] lane_hit
);

  logic [NUM_LINES-1:0] w_hit;
  logic [NUM_LINES-1:0] r_hit;
  logic                 r_raw;
  logic                 r_px;

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_lane
    gap_lane #(
      .LANE        (gi),
      .CW          (CW),
      .ROW0        (ROW0),
      .ROW_PITCH   (ROW_PITCH),
      .THICK       (THICK),
      .X_MIN       (X_MIN),
      .X_MAX       (X_MAX),
      .START_X     (START_X),
      .START_PITCH (START_PITCH),
      .STEP        (STEP)
    ) u_lane (
      .clk       (clk),
      .rst_n     (reset),
      .i_x       (x),
      .i_y       (y),
      .i_frame   (frame),
      .i_start   (start),
      .i_load    (load),
      .i_run     (run),
      .i_gap_sel (gap_sel),
      .o_wall    (w_hit[gi])
    );
  end

  // Frozen lanes blink via flash; collision always sees the ungated wall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit <= '0;
      r_raw <= 1'b0;
      r_px  <= 1'b0;
    end else begin
      r_hit <= w_hit;
      r_raw <= |w_hit;
      r_px  <= (|w_hit) && (run || flash);
    end
  end

  assign lane_hit = r_hit;
  assign line_raw = r_raw;
  assign line_px  = r_px;

endmodule

`default_nettype wire
